// File: rtl/zeroheti_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zeroheti_pkg
//  Description : Shared types for the zeroheti core. Holds the state encoding
//                and request bundle of the APB-to-OBI bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package zeroheti_pkg;

    // Default widths of the core's OBI crossbar; the request bundle uses them
    localparam int unsigned c_APB2OBI_AW = 32;
    localparam int unsigned c_APB2OBI_DW = 32;

    // Bridge sequencing: idle, OBI request pending, awaiting response, APB completion
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } apb2obi_state_e;

    // OBI request fields as presented by the bridge on its manager port
    typedef struct packed {
        logic [c_APB2OBI_AW-1:0]   addr;
        logic                      we;
        logic [c_APB2OBI_DW/8-1:0] be;
        logic [c_APB2OBI_DW-1:0]   wdata;
    } apb2obi_req_t;

endpackage
`default_nettype wire

// File: rtl/zeroheti_apb_to_obi.sv
`default_nettype none
// ============================================================================
//  Module      : zeroheti_apb_to_obi
//  Description : APB4 completer to OBI manager bridge. An external APB host
//                reaches the OBI crossbar through a single outstanding
//                transfer; APB wait states absorb the OBI latency. Accesses
//                outside the address window complete with PSLVERR and never
//                reach OBI.
//  Revision    : 1.0 - initial release
// ============================================================================
module zeroheti_apb_to_obi
    import zeroheti_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] WIN_BASE   = '0,
    parameter logic [ADDR_WIDTH-1:0] WIN_SIZE   = 'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] OBI_OFFSET = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] pstrb_i,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o,
    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic                    obi_we_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    output logic [DATA_WIDTH-1:0]   obi_wdata_o,
    input  logic                    obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
    input  logic                    obi_err_i
);

    localparam int unsigned c_BE_WIDTH = DATA_WIDTH / 8;

    apb2obi_state_e          r_state;
    logic [DATA_WIDTH-1:0]   r_prdata;
    logic                    r_pready;
    logic                    r_pslverr;
    logic                    r_req;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_we;
    logic [c_BE_WIDTH-1:0]   r_be;
    logic [DATA_WIDTH-1:0]   r_wdata;
    // APB host let go of psel mid-transfer; the OBI result is dropped
    logic                    r_abort;
    // A reset may have orphaned an in-flight OBI transfer; one late rvalid is expected
    logic                    r_stale_ok;

    logic [ADDR_WIDTH:0]     w_addr_ext;
    logic [ADDR_WIDTH:0]     w_win_lo;
    logic [ADDR_WIDTH:0]     w_win_hi;
    logic                    w_in_window;
    logic                    w_setup;
    logic                    w_access;
    logic [ADDR_WIDTH-1:0]   w_obi_addr;

    // One extra bit so a window ending exactly at 2^ADDR_WIDTH compares correctly
    assign w_addr_ext  = {1'b0, paddr_i};
    assign w_win_lo    = {1'b0, WIN_BASE};
    assign w_win_hi    = {1'b0, WIN_BASE} + {1'b0, WIN_SIZE};
    assign w_in_window = (w_addr_ext >= w_win_lo) && (w_addr_ext < w_win_hi);
    assign w_obi_addr  = paddr_i - WIN_BASE + OBI_OFFSET;
    assign w_setup     = psel_i & ~penable_i;
    assign w_access    = psel_i & penable_i;

    assign prdata_o    = r_prdata;
    assign pready_o    = r_pready;
    assign pslverr_o   = r_pslverr;
    assign obi_req_o   = r_req;
    assign obi_addr_o  = r_addr;
    assign obi_we_o    = r_we;
    assign obi_be_o    = r_be;
    assign obi_wdata_o = r_wdata;

    // Bridge sequencer: accept APB setup, issue OBI request, collect response, complete APB
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_prdata   <= '0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_abort    <= 1'b0;
            r_stale_ok <= 1'b1;
        end else begin
            if (obi_rvalid_i) begin
                r_stale_ok <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_setup) begin
                        r_stale_ok <= 1'b0;
                        r_abort    <= 1'b0;
                        if (w_in_window) begin
                            r_addr  <= w_obi_addr;
                            r_we    <= pwrite_i;
                            r_be    <= pwrite_i ? pstrb_i : {c_BE_WIDTH{1'b1}};
                            r_wdata <= pwdata_i;
                            r_req   <= 1'b1;
                            r_state <= REQ;
                        end else begin
                            r_prdata  <= '0;
                            r_pslverr <= 1'b1;
                            r_pready  <= 1'b1;
                            r_state   <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (!psel_i) begin
                        r_abort <= 1'b1;
                    end
                    if (obi_gnt_i) begin
                        r_req   <= 1'b0;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (!psel_i) begin
                        r_abort <= 1'b1;
                    end
                    if (obi_rvalid_i) begin
                        if (r_abort || !psel_i) begin
                            r_state <= IDLE;
                        end else begin
                            r_prdata  <= r_we ? '0 : obi_rdata_i;
                            r_pslverr <= obi_err_i;
                            r_pready  <= 1'b1;
                            r_state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (w_access || !psel_i) begin
                        r_prdata  <= '0;
                        r_pslverr <= 1'b0;
                        r_pready  <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A response outside RESP is ignored; only the orphan of a reset is legitimate
    a_rvalid_only_in_resp: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (obi_rvalid_i && (r_state != RESP)) |-> r_stale_ok
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_zeroheti_apb_to_obi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zeroheti_apb_to_obi
//  Description : Self-checking bench for the APB-to-OBI bridge. A memory-backed
//                OBI responder, an APB driver and a scoreboard monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zeroheti_apb_to_obi;
    import zeroheti_pkg::*;

    localparam logic [31:0]     c_WB  = 32'h1000_0000;
    localparam logic [31:0]     c_WS  = 32'h1000_0000;
    localparam logic [31:0]     c_OFF = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
    logic [31:0] paddr_i = '0, pwdata_i = '0;
    logic [3:0]  pstrb_i = '0;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o;
    logic        obi_req_o, obi_we_o;
    logic        obi_gnt_i = 1'b0, obi_rvalid_i = 1'b0, obi_err_i = 1'b0;
    logic [31:0] obi_addr_o, obi_wdata_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_rdata_i = '0;

    zeroheti_apb_to_obi #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .WIN_BASE   (c_WB),
        .WIN_SIZE   (c_WS),
        .OBI_OFFSET (c_OFF)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .psel_i       (psel_i),
        .penable_i    (penable_i),
        .pwrite_i     (pwrite_i),
        .paddr_i      (paddr_i),
        .pwdata_i     (pwdata_i),
        .pstrb_i      (pstrb_i),
        .prdata_o     (prdata_o),
        .pready_o     (pready_o),
        .pslverr_o    (pslverr_o),
        .obi_req_o    (obi_req_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_addr_o   (obi_addr_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_wdata_o  (obi_wdata_o),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rdata_i  (obi_rdata_i),
        .obi_err_i    (obi_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        longint      cyc;
    } resp_t;

    resp_t        exp_resp_q[$];
    apb2obi_req_t exp_obi_q[$];
    logic [31:0]  model_mem [64];
    logic [31:0]  slave_mem [64];
    longint       cyc = 0;
    int           checks = 0;
    int           errors = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Scoreboard monitor: APB completions, OBI handshakes, request stability
    logic        prev_req = 1'b0, prev_gnt = 1'b0;
    logic [31:0] prev_addr = '0;
    always @(negedge clk_i) begin
        resp_t        e;
        apb2obi_req_t q;
        if (!rst_i) begin
            if (pready_o) begin
                if (exp_resp_q.size() == 0) check("unexpected_pready", 64'd1, 64'd0);
                else begin
                    e = exp_resp_q.pop_front();
                    check("prdata", 64'(prdata_o), 64'(e.rdata));
                    check("pslverr", 64'(pslverr_o), 64'(e.err));
                    check("pready_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (obi_req_o && obi_gnt_i) begin
                if (exp_obi_q.size() == 0) check("unexpected_obi_req", 64'd1, 64'd0);
                else begin
                    q = exp_obi_q.pop_front();
                    check("obi_addr", 64'(obi_addr_o), 64'(q.addr));
                    check("obi_we", 64'(obi_we_o), 64'(q.we));
                    check("obi_be", 64'(obi_be_o), 64'(q.be));
                    check("obi_wdata", 64'(obi_wdata_o), 64'(q.wdata));
                end
                if (obi_we_o)
                    slave_mem[obi_addr_o[7:2]] = merge(slave_mem[obi_addr_o[7:2]], obi_wdata_o, obi_be_o);
            end
            if (prev_req && !prev_gnt) begin
                check("req_held", 64'(obi_req_o), 64'd1);
                check("addr_stable", 64'(obi_addr_o), 64'(prev_addr));
            end
            prev_req  = obi_req_o;
            prev_gnt  = obi_gnt_i;
            prev_addr = obi_addr_o;
        end else begin
            prev_req = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One APB transfer with a scripted OBI responder; pushes the expected outcome first
    task automatic do_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [3:0] sb, input int gd, input int rd, input logic e);
        longint unsigned la;
        logic            inwin;
        logic [31:0]     oaddr;
        resp_t           r;
        apb2obi_req_t    q;
        la    = longint'(a);
        inwin = (la >= longint'(c_WB)) && (la < longint'(c_WB) + longint'(c_WS));
        oaddr = 32'(la - longint'(c_WB) + longint'(c_OFF));
        if (inwin) begin
            q.addr = oaddr; q.we = w; q.be = w ? sb : 4'hF; q.wdata = wd;
            exp_obi_q.push_back(q);
            r.rdata = w ? 32'h0 : model_mem[oaddr[7:2]];
            r.err   = e;
            r.cyc   = cyc + 3 + gd + rd;
            if (w) model_mem[oaddr[7:2]] = merge(model_mem[oaddr[7:2]], wd, sb);
        end else begin
            r.rdata = 32'h0;
            r.err   = 1'b1;
            r.cyc   = cyc + 1;
        end
        exp_resp_q.push_back(r);
        fork
            begin
                int n;
                psel_i = 1'b1; penable_i = 1'b0; paddr_i = a;
                pwrite_i = w; pwdata_i = wd; pstrb_i = sb;
                tick();
                penable_i = 1'b1;
                n = 0;
                while (!pready_o) begin
                    if (n >= 100) begin
                        check("pready_timeout", 64'd0, 64'd1);
                        break;
                    end
                    tick();
                    n++;
                end
                tick();
                psel_i = 1'b0; penable_i = 1'b0;
            end
            begin
                int n;
                logic [31:0] ga;
                if (inwin) begin
                    n = 0;
                    while (!obi_req_o && n < 100) begin
                        tick();
                        n++;
                    end
                    if (!obi_req_o) check("obi_req_timeout", 64'd0, 64'd1);
                    else begin
                        repeat (gd) tick();
                        obi_gnt_i = 1'b1;
                        ga = obi_addr_o;
                        tick();
                        obi_gnt_i = 1'b0;
                        repeat (rd) tick();
                        obi_rvalid_i = 1'b1;
                        obi_err_i    = e;
                        obi_rdata_i  = w ? $urandom : slave_mem[ga[7:2]];
                        tick();
                        obi_rvalid_i = 1'b0;
                        obi_err_i    = 1'b0;
                        obi_rdata_i  = $urandom;
                    end
                end
            end
        join
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            model_mem[i] = 32'hC0DE_0000 ^ (i * 32'h0101_0307);
            slave_mem[i] = model_mem[i];
        end
        rst_i = 1'b1;
        repeat (3) tick();
        check("rst_pready", 64'(pready_o), 64'd0);
        check("rst_pslverr", 64'(pslverr_o), 64'd0);
        check("rst_prdata", 64'(prdata_o), 64'd0);
        check("rst_obi_req", 64'(obi_req_o), 64'd0);
        check("rst_obi_addr", 64'(obi_addr_o), 64'd0);
        check("rst_obi_fields", 64'({obi_we_o, obi_be_o, obi_wdata_o}), 64'd0);
        rst_i = 1'b0;
        tick();

        // Full-word write, immediate grant and response
        do_xfer(c_WB + 32'h100, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b0);
        // Read after a stalled grant
        do_xfer(c_WB + 32'h104, 1'b1, 32'h1234_5678, 4'hF, 0, 0, 1'b0);
        do_xfer(c_WB + 32'h104, 1'b0, 32'h0, 4'h0, 3, 0, 1'b0);
        // Just below the window, first and last addresses of the window, just above it
        do_xfer(32'h0FFF_FFFC, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0);
        do_xfer(c_WB, 1'b0, 32'h0, 4'h0, 0, 1, 1'b0);
        do_xfer(32'h1FFF_FFFC, 1'b1, 32'hA5A5_5A5A, 4'hF, 1, 0, 1'b0);
        do_xfer(32'h2000_0000, 1'b1, 32'h1111_2222, 4'hF, 0, 0, 1'b0);
        // OBI error then clean read
        do_xfer(c_WB + 32'h40, 1'b1, 32'hCAFE_F00D, 4'hF, 0, 2, 1'b1);
        do_xfer(c_WB + 32'h40, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0);

        // Reset while waiting for the response; the late rvalid must be ignored
        begin
            apb2obi_req_t q;
            q.addr = c_WB + c_OFF + 32'h80 - c_WB; q.we = 1'b0; q.be = 4'hF; q.wdata = 32'h0;
            exp_obi_q.push_back(q);
            psel_i = 1'b1; penable_i = 1'b0; paddr_i = c_WB + 32'h80; pwrite_i = 1'b0;
            pwdata_i = 32'h0; pstrb_i = 4'h0;
            tick();
            penable_i = 1'b1;
            check("abort_req_issued", 64'(obi_req_o), 64'd1);
            obi_gnt_i = 1'b1;
            tick();
            obi_gnt_i = 1'b0;
            rst_i = 1'b1;
            tick();
            rst_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
            check("abort_pready", 64'(pready_o), 64'd0);
            check("abort_outputs", 64'({pslverr_o, obi_req_o, obi_we_o, obi_be_o}), 64'd0);
            check("abort_prdata", 64'(prdata_o), 64'd0);
            obi_rvalid_i = 1'b1; obi_rdata_i = 32'hBAD0_BAD0;
            tick();
            obi_rvalid_i = 1'b0;
            check("late_rvalid_ignored", 64'({pready_o, obi_req_o}), 64'd0);
            tick();
            check("late_rvalid_idle", 64'({pready_o, obi_req_o}), 64'd0);
        end
        do_xfer(c_WB + 32'h80, 1'b0, 32'h0, 4'h0, 1, 1, 1'b0);

        // Byte write followed immediately by a read of the same word
        do_xfer(c_WB + 32'h20, 1'b1, 32'h00AB_0000, 4'b0100, 0, 0, 1'b0);
        do_xfer(c_WB + 32'h20, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            int unsigned sel;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = c_WB + 32'($urandom_range(0, 63) << 2);
            else if (sel == 7) a = 32'h1FFF_FF00 + 32'($urandom_range(0, 63) << 2);
            else if (sel == 8) a = 32'h2000_0000 + 32'($urandom_range(0, 15) << 2);
            else               a = 32'h0FFF_FFC0 + 32'($urandom_range(0, 15) << 2);
            do_xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) tick();
        end

        repeat (4) tick();
        check("resp_queue_drained", 64'(exp_resp_q.size()), 64'd0);
        check("obi_queue_drained", 64'(exp_obi_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
